mem_bus_arbiter: RTL and testbench

//  Shares one memory bus between the fetch port (IF, read-only) and the EX-stage load/store port.
//  - Registers the winning request onto the bus and waits for the bus handshake.
//  - Returns read data plus a one-cycle ack to the winner.
//  - Drives stall outputs that freeze the pipeline while an access is in flight.
//  - Sits between the EX-stage memory outputs / IF fetch logic and the external memory interface.

---
 rtl/mem_bus_arbiter_if.sv | 24 ++
 rtl/mem_bus_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Memory-side bus of the IF/EX arbiter: one request channel with a ready/rdata return.
// The master modport belongs to the arbiter; the slave modport to the memory.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              bus_valid;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [7:0]        bus_wmask;
    logic              bus_ready;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_wdata, bus_wmask,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_wdata, bus_wmask,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the fetch port and the EX load/store port onto one memory bus (EX wins).
// Define MEM_ARB_TIMEOUT_EN to abort bus accesses that wait TIMEOUT cycles (ack with bus_err).
module mem_bus_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              ex_rd_en,
    input  logic              ex_wr_en,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [7:0]        ex_wmask,
    output logic              ex_ack,
    output logic [DATA_W-1:0] ex_rdata,

    output logic              stall_if,
    output logic              stall_ex,
    output logic              bus_err,

    mem_bus_arbiter_if.master mem
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_reg;
    logic              owner_ex_reg;
    logic              valid_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [7:0]        wmask_reg;
    logic              if_ack_reg;
    logic              ex_ack_reg;
    logic [DATA_W-1:0] if_rdata_reg;
    logic [DATA_W-1:0] ex_rdata_reg;
    logic              err_reg;

    logic              ex_pending;
    logic              timeout_hit;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_bus_arbiter: TIMEOUT must be at least 1");
    end

    assign ex_pending = ex_rd_en | ex_wr_en;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] wait_cnt_reg;

    // Held at zero outside BUS, so every access starts counting from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_reg <= '0;
        end else if (state_reg != ST_BUS) begin
            wait_cnt_reg <= '0;
        end else if (!mem.bus_ready) begin
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
        end
    end

    assign timeout_hit = (state_reg == ST_BUS) && !mem.bus_ready &&
                         (wait_cnt_reg == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            owner_ex_reg <= 1'b0;
            valid_reg    <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            wmask_reg    <= '0;
            if_ack_reg   <= 1'b0;
            ex_ack_reg   <= 1'b0;
            if_rdata_reg <= '0;
            ex_rdata_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            // Acks, response data and the error flag live for one cycle only.
            if_ack_reg   <= 1'b0;
            ex_ack_reg   <= 1'b0;
            if_rdata_reg <= '0;
            ex_rdata_reg <= '0;
            err_reg      <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (ex_pending) begin
                        owner_ex_reg <= 1'b1;
                        we_reg       <= ex_wr_en;
                        addr_reg     <= ex_addr;
                        wdata_reg    <= ex_wr_en ? ex_wdata : '0;
                        wmask_reg    <= ex_wr_en ? ex_wmask : 8'h00;
                        valid_reg    <= 1'b1;
                        state_reg    <= ST_BUS;
                    end else if (if_req) begin
                        owner_ex_reg <= 1'b0;
                        we_reg       <= 1'b0;
                        addr_reg     <= if_addr;
                        wdata_reg    <= '0;
                        wmask_reg    <= 8'h00;
                        valid_reg    <= 1'b1;
                        state_reg    <= ST_BUS;
                    end
                end

                ST_BUS: begin
                    if (mem.bus_ready) begin
                        valid_reg <= 1'b0;
                        state_reg <= ST_RESP;
                        if (owner_ex_reg) begin
                            ex_ack_reg   <= 1'b1;
                            ex_rdata_reg <= we_reg ? '0 : mem.bus_rdata;
                        end else begin
                            if_ack_reg   <= 1'b1;
                            if_rdata_reg <= mem.bus_rdata;
                        end
                    end else if (timeout_hit) begin
                        valid_reg  <= 1'b0;
                        state_reg  <= ST_RESP;
                        err_reg    <= 1'b1;
                        ex_ack_reg <= owner_ex_reg;
                        if_ack_reg <= !owner_ex_reg;
                    end
                end

                ST_RESP: begin
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign mem.bus_valid = valid_reg;
    assign mem.bus_we    = we_reg;
    assign mem.bus_addr  = addr_reg;
    assign mem.bus_wdata = wdata_reg;
    assign mem.bus_wmask = wmask_reg;

    assign if_ack   = if_ack_reg;
    assign ex_ack   = ex_ack_reg;
    assign if_rdata = if_rdata_reg;
    assign ex_rdata = ex_rdata_reg;
    assign bus_err  = err_reg;

    // The ack cycle releases the stall in that same cycle.
    assign stall_if = if_req & ~if_ack_reg;
    assign stall_ex = ex_pending & ~ex_ack_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scenarios plus randomized traffic for mem_bus_arbiter, checked every cycle
// against a transaction-level reference model.
module tb_mem_bus_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          ex_rd_en;
    logic          ex_wr_en;
    logic [AW-1:0] ex_addr;
    logic [DW-1:0] ex_wdata;
    logic [7:0]    ex_wmask;
    logic          ex_ack;
    logic [DW-1:0] ex_rdata;
    logic          stall_if;
    logic          stall_ex;
    logic          bus_err;

    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem ();

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .ex_rd_en (ex_rd_en),
        .ex_wr_en (ex_wr_en),
        .ex_addr  (ex_addr),
        .ex_wdata (ex_wdata),
        .ex_wmask (ex_wmask),
        .ex_ack   (ex_ack),
        .ex_rdata (ex_rdata),
        .stall_if (stall_if),
        .stall_ex (stall_ex),
        .bus_err  (bus_err),
        .mem      (mem)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // ---------------- reference model: one outstanding access at most ----------------
    bit            m_live   = 1'b0;
    bit            m_on_bus = 1'b0;
    bit            m_ack    = 1'b0;
    bit            m_err    = 1'b0;
    bit            m_ex     = 1'b0;
    bit            m_we     = 1'b0;
    logic [AW-1:0] m_addr   = '0;
    logic [DW-1:0] m_wdata  = '0;
    logic [7:0]    m_wmask  = '0;
    logic [DW-1:0] m_data   = '0;
    int            m_wait   = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                automatic bit e_if_ack = m_ack && !m_ex;
                automatic bit e_ex_ack = m_ack && m_ex;
                check("m_bus_valid", mem.bus_valid, m_on_bus);
                if (m_on_bus) begin
                    check("m_bus_we", mem.bus_we, m_we);
                    check("m_bus_addr", mem.bus_addr, m_addr);
                    check("m_bus_wmask", mem.bus_wmask, m_wmask);
                    if (m_we) check("m_bus_wdata", mem.bus_wdata, m_wdata);
                end
                check("m_if_ack", if_ack, e_if_ack);
                check("m_ex_ack", ex_ack, e_ex_ack);
                check("m_if_rdata", if_rdata, e_if_ack ? m_data : 64'd0);
                check("m_ex_rdata", ex_rdata, e_ex_ack ? m_data : 64'd0);
                check("m_bus_err", bus_err, m_ack && m_err);
                check("m_stall_if", stall_if, if_req && !e_if_ack);
                check("m_stall_ex", stall_ex, (ex_rd_en || ex_wr_en) && !e_ex_ack);
            end

            // Advance by one cycle using the inputs the DUT samples at the next edge.
            if (m_ack) begin
                m_ack = 1'b0;
            end else if (m_on_bus) begin
                if (mem.bus_ready) begin
                    m_on_bus = 1'b0;
                    m_ack    = 1'b1;
                    m_err    = 1'b0;
                    m_data   = m_we ? 64'd0 : mem.bus_rdata;
                end else begin
                    m_wait++;
`ifdef MEM_ARB_TIMEOUT_EN
                    if (m_wait == TO) begin
                        m_on_bus = 1'b0;
                        m_ack    = 1'b1;
                        m_err    = 1'b1;
                        m_data   = 64'd0;
                    end
`endif
                end
            end else if (ex_rd_en || ex_wr_en) begin
                m_on_bus = 1'b1;
                m_ex     = 1'b1;
                m_we     = ex_wr_en;
                m_addr   = ex_addr;
                m_wdata  = ex_wr_en ? ex_wdata : 64'd0;
                m_wmask  = ex_wr_en ? ex_wmask : 8'h00;
                m_wait   = 0;
            end else if (if_req) begin
                m_on_bus = 1'b1;
                m_ex     = 1'b0;
                m_we     = 1'b0;
                m_addr   = if_addr;
                m_wdata  = 64'd0;
                m_wmask  = 8'h00;
                m_wait   = 0;
            end

            if (rst === 1'b1) begin
                m_on_bus = 1'b0;
                m_ack    = 1'b0;
                m_err    = 1'b0;
                m_live   = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int vcnt;
        int acnt;
        int ecnt;
        bit ia;
        bit ea;

        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        ex_rd_en = 1'b0; ex_wr_en = 1'b0; ex_addr = '0; ex_wdata = '0; ex_wmask = '0;
        mem.bus_ready = 1'b0; mem.bus_rdata = '0;
        repeat (3) @(posedge clk);
        smp();
        check("rst_bus_valid", mem.bus_valid, 1'b0);
        check("rst_bus_we", mem.bus_we, 1'b0);
        check("rst_bus_addr", mem.bus_addr, 64'd0);
        check("rst_bus_wmask", mem.bus_wmask, 8'h00);
        check("rst_acks", {if_ack, ex_ack, bus_err}, 3'b000);
        check("rst_rdata", if_rdata | ex_rdata, 64'd0);
        tick(); rst = 1'b0;

        // 1: single IF read
        tick(); if_req = 1'b1; if_addr = 64'h8000_0000;
        smp();  check("t1_stall_c0", stall_if, 1'b1);
                check("t1_valid_c0", mem.bus_valid, 1'b0);
        tick(); mem.bus_ready = 1'b1; mem.bus_rdata = 64'h13;
        smp();  check("t1_valid_c1", mem.bus_valid, 1'b1);
                check("t1_addr_c1", mem.bus_addr, 64'h8000_0000);
                check("t1_stall_c1", stall_if, 1'b1);
        tick();
        smp();  check("t1_ack_c2", if_ack, 1'b1);
                check("t1_rdata_c2", if_rdata, 64'h13);
                check("t1_stall_c2", stall_if, 1'b0);
        tick(); if_req = 1'b0; mem.bus_ready = 1'b0;
        smp();  check("t1_ack_c3", if_ack, 1'b0);
                check("t1_rdata_c3", if_rdata, 64'd0);

        // 2: collision, EX first then IF
        tick(); if_req = 1'b1; if_addr = 64'hA0; ex_rd_en = 1'b1; ex_addr = 64'hB0;
                mem.bus_ready = 1'b1; mem.bus_rdata = 64'h77;
        smp();  check("t2_stalls_c0", {stall_if, stall_ex}, 2'b11);
        tick();
        smp();  check("t2_addr_c1", mem.bus_addr, 64'hB0);
        tick();
        smp();  check("t2_acks_c2", {ex_ack, if_ack}, 2'b10);
                check("t2_exdata_c2", ex_rdata, 64'h77);
        tick(); ex_rd_en = 1'b0;
        smp();  check("t2_valid_c3", mem.bus_valid, 1'b0);
        tick();
        smp();  check("t2_valid_c4", mem.bus_valid, 1'b1);
                check("t2_addr_c4", mem.bus_addr, 64'hA0);
        tick();
        smp();  check("t2_ifack_c5", if_ack, 1'b1);
                check("t2_ifdata_c5", if_rdata, 64'h77);
        tick(); if_req = 1'b0; mem.bus_ready = 1'b0;

        // 3: store with ready delayed three cycles
        tick(); ex_wr_en = 1'b1; ex_addr = 64'h300; ex_wdata = 64'hAB; ex_wmask = 8'h01;
                mem.bus_rdata = 64'hDEAD;
        acnt = 0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 4) mem.bus_ready = 1'b1;
            if (c == 6) begin ex_wr_en = 1'b0; mem.bus_ready = 1'b0; end
            smp();
            if (c <= 4) begin
                check("t3_hold", {mem.bus_valid, mem.bus_we, mem.bus_wmask}, {2'b11, 8'h01});
                check("t3_wdata", mem.bus_wdata, 64'hAB);
            end
            if (c == 5) check("t3_ack_c5", ex_ack, 1'b1);
            if (c == 5) check("t3_rdata_c5", ex_rdata, 64'd0);
            if (ex_ack) acnt++;
        end
        check("t3_ack_count", acnt, 1);

        // 4: reset while the bus is busy
        tick(); if_req = 1'b1; if_addr = 64'h1000;
        smp();
        tick();
        smp();  check("t4_valid_c1", mem.bus_valid, 1'b1);
        tick(); rst = 1'b1; if_req = 1'b0;
        smp();
        tick(); rst = 1'b0;
        smp();  check("t4_valid_c3", mem.bus_valid, 1'b0);
                check("t4_acks_c3", {if_ack, ex_ack}, 2'b00);
        tick();
        smp();  check("t4_acks_c4", {if_ack, ex_ack, mem.bus_valid}, 3'b000);
        tick(); ex_rd_en = 1'b1; ex_addr = 64'h2000; mem.bus_ready = 1'b1; mem.bus_rdata = 64'h55;
        smp();
        tick();
        smp();  check("t4_addr_c6", mem.bus_addr, 64'h2000);
        tick();
        smp();  check("t4_ack_c7", ex_ack, 1'b1);
                check("t4_rdata_c7", ex_rdata, 64'h55);
        tick(); ex_rd_en = 1'b0; mem.bus_ready = 1'b0;

`ifdef MEM_ARB_TIMEOUT_EN
        // 5: bus never ready, access aborted after TIMEOUT waiting cycles
        tick(); if_req = 1'b1; if_addr = 64'h40;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 6) if_req = 1'b0;
            smp();
            if (c <= TO) check("t5_valid", mem.bus_valid, 1'b1);
            if (c == TO + 1) begin
                check("t5_ack_err", {if_ack, bus_err, mem.bus_valid}, 3'b110);
                check("t5_rdata", if_rdata, 64'd0);
            end
            if (c > TO + 1) check("t5_after", {mem.bus_valid, bus_err}, 2'b00);
        end
`else
        // 6: bus never ready, access waits indefinitely
        tick(); if_req = 1'b1; if_addr = 64'h40;
        vcnt = 0; acnt = 0; ecnt = 0;
        for (int c = 1; c <= 110; c++) begin
            tick();
            smp();
            if (mem.bus_valid) vcnt++;
            if (if_ack || ex_ack) acnt++;
            if (bus_err) ecnt++;
        end
        check("t6_valid_cycles", vcnt, 110);
        check("t6_ack_count", acnt, 0);
        check("t6_err_count", ecnt, 0);
        tick(); rst = 1'b1; if_req = 1'b0;
        tick(); rst = 1'b0;
`endif

        // randomized traffic; requesters hold until ack and drop at the ack edge
        ia = 1'b0; ea = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst = ($urandom_range(0, 399) == 0);
            if (rst) begin
                if_req = 1'b0; ex_rd_en = 1'b0; ex_wr_en = 1'b0;
            end else begin
                if (ia || (if_req && $urandom_range(0, 59) == 0)) begin
                    if_req = 1'b0;
                end else if (!if_req && $urandom_range(0, 2) == 0) begin
                    if_req = 1'b1; if_addr = {$urandom, $urandom};
                end
                if (ea || ((ex_rd_en || ex_wr_en) && $urandom_range(0, 59) == 0)) begin
                    ex_rd_en = 1'b0; ex_wr_en = 1'b0;
                end else if (!(ex_rd_en || ex_wr_en) && $urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 2))
                        0:       begin ex_rd_en = 1'b1; ex_wr_en = 1'b0; end
                        1:       begin ex_rd_en = 1'b0; ex_wr_en = 1'b1; end
                        default: begin ex_rd_en = 1'b1; ex_wr_en = 1'b1; end
                    endcase
                    ex_addr  = {$urandom, $urandom};
                    ex_wdata = {$urandom, $urandom};
                    ex_wmask = 8'($urandom);
                end
            end
            mem.bus_ready = ($urandom_range(0, 2) == 0);
            mem.bus_rdata = {$urandom, $urandom};
            smp();
            ia = if_ack;
            ea = ex_ack;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
